x86_instr_encoder: RTL
======================

// Module: x86_instr_encoder
// PURPOSE
//  Inverse of the opcode decode maps: serialises one encoded-instruction descriptor into an x86-64 byte stream.
//  Byte order: REX, escape bytes, opcode, ModRM, immediate/displacement (little-endian). One byte per cycle.
//  Sits between the instruction-generation/test-stimulus logic and any byte-stream consumer (fetch model, decoder BIST).
// PARAMETERS
//  IMM_MAX_BYTES  8  largest immediate in bytes (movabs Iv); in_imm width = 8*IMM_MAX_BYTES
// PORTS
//  clk            in   1   clock, all state on rising edge
//  reset_n        in   1   asynchronous active-low reset
//  in_valid       in   1   descriptor valid
//  in_ready       out  1   descriptor accepted when in_valid && in_ready
//  in_rex         in   8   REX byte; 8'h00 = no REX, else must be 8'h40..8'h4F
//  in_map         in   2   0: one-byte map, 1: 0F, 2: 0F 38, 3: 0F 3A
//  in_opcode      in   8   final opcode byte
//  in_has_modrm   in   1   emit in_modrm after opcode (groups, Ev/Gv modes)
//  in_modrm       in   8   ModRM byte
//  in_imm_len     in   4   immediate bytes: 0,1,2,4,8 legal
//  in_imm         in   64  immediate value, byte 0 = LSB
//  out_valid      out  1   out_byte valid
//  out_ready      in   1   consumer takes byte when out_valid && out_ready
//  out_byte       out  8   current byte
//  out_first      out  1   current byte is first of instruction
//  out_last       out  1   current byte is last of instruction
//  out_len        out  4   total instruction length, valid with out_last
//  err            out  1   one-cycle pulse: illegal descriptor dropped
// BEHAVIOUR
//  Reset (async, reset_n low): state IDLE, out_valid=0, out_byte=0, out_first=0, out_last=0, out_len=0, err=0;
//   in_ready forced 0 while reset_n low. Reset mid-instruction abandons remaining bytes; no partial resume.
//  Accept: descriptor registered on handshake; fields never re-sampled from inputs afterwards.
//  in_ready = (state==IDLE) || (out_valid && out_ready && out_last); back-to-back instructions, zero bubble.
//  Latency: first byte on out_valid the cycle after acceptance.
//  States: IDLE -> REX -> ESC0 -> ESC1 -> OPC -> MODRM -> IMM -> IDLE/next. Absent fields skipped:
//   REX iff in_rex!=0; ESC0 (8'h0F) iff map!=0; ESC1 (8'h38 map2 / 8'h3A map3) iff map>=2; OPC always;
//   MODRM iff in_has_modrm; IMM iff imm_len!=0, counter 0..imm_len-1 emits imm[8*i +: 8].
//  State advances only on out_valid && out_ready; when out_ready=0, out_byte/out_first/out_last held stable.
//  out_len = (rex!=0)+(map==0?0:map==1?1:2)+1+has_modrm+imm_len; range 1..13, computed at accept.
//  Illegal: imm_len not in {0,1,2,4,8}, or in_rex!=0 with in_rex[7:4]!=4'h4 -> descriptor consumed,
//   err=1 the following cycle, no bytes emitted, state stays IDLE.
//  Accept on last-byte handshake with illegal descriptor: err pulses, out_valid drops to 0 next cycle.
//  out_first=1 only on the first emitted byte; single-byte instruction has out_first=out_last=1.
// TESTING
//  rex=48,map0,opc=89,modrm=C3,imm_len0 -> 48,89,C3; first on 48, last+len=3 on C3, first byte 1 cycle after accept
//  rex=48,opc=B8,imm_len8,imm=1122334455667788 -> 48,B8,88,77,66,55,44,33,22,11; len=10
//  map1,opc=84,imm_len4,imm=00000010, out_ready toggling 1/0 -> 0F,84,10,00,00,00, held while stalled, no dup/drop
//  map3,opc=0F,modrm=C1,imm_len1,imm=05 -> 0F,3A,0F,C1,05; then opc=C3 back-to-back -> C3 next cycle, first=last=1, len=1
//  imm_len=3 (or rex=8'h50) -> err pulse 1 cycle, out_valid stays 0, next legal descriptor encodes normally
//  reset_n low after 2 of 10 movabs bytes -> out_valid=0 immediately; next accept starts clean at REX byte

Source files
------------

// File: rtl/x86_instr_encoder_if.sv
// Descriptor-in / byte-stream-out bundle for the x86-64 instruction encoder.
// The master drives descriptors and consumes bytes; the slave is the encoder.
interface x86_instr_encoder_if #(
    parameter int IMM_MAX_BYTES = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic [7:0]                   in_rex;
    logic [1:0]                   in_map;
    logic [7:0]                   in_opcode;
    logic                         in_has_modrm;
    logic [7:0]                   in_modrm;
    logic [3:0]                   in_imm_len;
    logic [8*IMM_MAX_BYTES-1:0]   in_imm;

    logic                         out_valid;
    logic                         out_ready;
    logic [7:0]                   out_byte;
    logic                         out_first;
    logic                         out_last;
    logic [3:0]                   out_len;
    logic                         err;

    modport master (
        output in_valid, in_rex, in_map, in_opcode, in_has_modrm, in_modrm,
               in_imm_len, in_imm, out_ready,
        input  in_ready, out_valid, out_byte, out_first, out_last, out_len, err
    );

    modport slave (
        input  in_valid, in_rex, in_map, in_opcode, in_has_modrm, in_modrm,
               in_imm_len, in_imm, out_ready,
        output in_ready, out_valid, out_byte, out_first, out_last, out_len, err
    );
endinterface

// File: rtl/x86_instr_encoder.sv
// Serialises one instruction descriptor into x86-64 bytes, one byte per cycle:
// REX, escape bytes, opcode, ModRM, little-endian immediate.
module x86_instr_encoder #(
    parameter int IMM_MAX_BYTES = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    x86_instr_encoder_if.slave   bus
);
    localparam int IMM_BITS = 8 * IMM_MAX_BYTES;
    localparam int CNT_W    = (IMM_MAX_BYTES > 1) ? $clog2(IMM_MAX_BYTES) : 1;

    // state_q names the field whose byte is currently presented on out_byte
    typedef enum logic [2:0] {
        S_IDLE, S_REX, S_ESC0, S_ESC1, S_OPC, S_MODRM, S_IMM
    } state_t;

    function automatic state_t step(state_t s, logic rex_nz, logic [1:0] map,
                                    logic has_modrm, logic [3:0] imm_len,
                                    logic [CNT_W-1:0] cnt);
        state_t after_opc;
        after_opc = has_modrm ? S_MODRM : ((imm_len != 4'd0) ? S_IMM : S_IDLE);
        case (s)
            S_IDLE:  return rex_nz ? S_REX : ((map != 2'd0) ? S_ESC0 : S_OPC);
            S_REX:   return (map != 2'd0) ? S_ESC0 : S_OPC;
            S_ESC0:  return (map >= 2'd2) ? S_ESC1 : S_OPC;
            S_ESC1:  return S_OPC;
            S_OPC:   return after_opc;
            S_MODRM: return (imm_len != 4'd0) ? S_IMM : S_IDLE;
            S_IMM:   return (4'(cnt) == imm_len - 4'd1) ? S_IDLE : S_IMM;
            default: return S_IDLE;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(state_t s, logic [7:0] rex, logic [1:0] map,
                                           logic [7:0] opc, logic [7:0] modrm,
                                           logic [IMM_BITS-1:0] imm, logic [CNT_W-1:0] cnt);
        case (s)
            S_REX:   return rex;
            S_ESC0:  return 8'h0F;
            S_ESC1:  return (map == 2'd2) ? 8'h38 : 8'h3A;
            S_OPC:   return opc;
            S_MODRM: return modrm;
            S_IMM:   return imm[{cnt, 3'b000} +: 8];
            default: return 8'h00;
        endcase
    endfunction

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [7:0]           rex_q;
    logic [1:0]           map_q;
    logic [7:0]           opc_q;
    logic                 has_modrm_q;
    logic [7:0]           modrm_q;
    logic [3:0]           imm_len_q;
    logic [IMM_BITS-1:0]  imm_q;
    logic                 out_valid_q;
    logic [7:0]           out_byte_q;
    logic                 out_first_q;
    logic                 out_last_q;
    logic [3:0]           out_len_q;
    logic                 err_q;

    logic rex_nz_in, imm_len_ok, in_legal, accept, take;
    assign rex_nz_in  = (bus.in_rex != 8'h00);
    assign imm_len_ok = (bus.in_imm_len inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd8}) &&
                        (int'(bus.in_imm_len) <= IMM_MAX_BYTES);
    assign in_legal   = imm_len_ok && (!rex_nz_in || bus.in_rex[7:4] == 4'h4);
    assign take       = out_valid_q && bus.out_ready;
    assign accept     = bus.in_valid && bus.in_ready;

    // NOTE: in_ready is combinational so a new descriptor can ride the last-byte handshake.
    assign bus.in_ready = reset_n && ((state_q == S_IDLE) || (take && out_last_q));

    // First byte of an incoming descriptor, taken straight from the inputs
    state_t     acc_state;
    logic       acc_last;
    logic [7:0] acc_byte;
    logic [3:0] acc_len;
    assign acc_state = step(S_IDLE, rex_nz_in, bus.in_map, bus.in_has_modrm,
                            bus.in_imm_len, '0);
    assign acc_last  = (step(acc_state, rex_nz_in, bus.in_map, bus.in_has_modrm,
                             bus.in_imm_len, '0) == S_IDLE);
    assign acc_byte  = byte_of(acc_state, bus.in_rex, bus.in_map, bus.in_opcode,
                               bus.in_modrm, bus.in_imm, '0);
    assign acc_len   = 4'(rex_nz_in)
                     + ((bus.in_map == 2'd0) ? 4'd0 : (bus.in_map == 2'd1) ? 4'd1 : 4'd2)
                     + 4'd1 + 4'(bus.in_has_modrm) + bus.in_imm_len;

    // Following byte of the registered descriptor
    state_t           adv_state;
    logic [CNT_W-1:0] adv_cnt;
    logic             adv_last;
    logic [7:0]       adv_byte;
    assign adv_cnt   = (state_q == S_IMM) ? cnt_q + 1'b1 : '0;
    assign adv_state = step(state_q, rex_q != 8'h00, map_q, has_modrm_q, imm_len_q, cnt_q);
    assign adv_last  = (step(adv_state, rex_q != 8'h00, map_q, has_modrm_q, imm_len_q,
                             adv_cnt) == S_IDLE);
    assign adv_byte  = byte_of(adv_state, rex_q, map_q, opc_q, modrm_q, imm_q, adv_cnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rex_q       <= '0;
            map_q       <= '0;
            opc_q       <= '0;
            has_modrm_q <= 1'b0;
            modrm_q     <= '0;
            imm_len_q   <= '0;
            imm_q       <= '0;
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_len_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (take && !out_last_q) begin
                state_q     <= adv_state;
                cnt_q       <= adv_cnt;
                out_byte_q  <= adv_byte;
                out_first_q <= 1'b0;
                out_last_q  <= adv_last;
            end else if (accept) begin
                if (!in_legal) begin
                    err_q       <= 1'b1;
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    out_first_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end else begin
                    rex_q       <= bus.in_rex;
                    map_q       <= bus.in_map;
                    opc_q       <= bus.in_opcode;
                    has_modrm_q <= bus.in_has_modrm;
                    modrm_q     <= bus.in_modrm;
                    imm_len_q   <= bus.in_imm_len;
                    imm_q       <= bus.in_imm;
                    state_q     <= acc_state;
                    cnt_q       <= '0;
                    out_valid_q <= 1'b1;
                    out_byte_q  <= acc_byte;
                    out_first_q <= 1'b1;
                    out_last_q  <= acc_last;
                    out_len_q   <= acc_len;
                end
            end else if (take) begin
                state_q     <= S_IDLE;
                out_valid_q <= 1'b0;
                out_first_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_byte  = out_byte_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_len   = out_len_q;
    assign bus.err       = err_q;
endmodule
